// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit ripple-carry slice, one nibble per clock.
// Ports: clk, reset (sync, active-high); start/a/b/cin request (sampled in IDLE only);
//        busy (add in flight), done (1-cycle pulse), sum/cout (registered, held until next completion).
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  // Keep the counter at least one bit wide so WIDTH=4 still elaborates.
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, a_sr_nxt;
  logic [WIDTH-1:0] b_sr, b_sr_nxt;
  logic [WIDTH-1:0] psum, psum_nxt, psum_shift;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry, carry_nxt;
  logic             cout_nxt, done_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  // 4-bit ripple-carry slice on the low nibble of the operand shift registers.
  always_comb begin : slice
    logic c;
    c         = carry;
    slice_sum = '0;
    for (int i = 0; i < 4; i++) begin
      slice_sum[i] = a_sr[i] ^ b_sr[i] ^ c;
      c            = (a_sr[i] & b_sr[i]) | (c & (a_sr[i] ^ b_sr[i]));
    end
    slice_cout = c;
  end

  // New sum nibble enters from the top; after NIB shifts nibble 0 sits at the bottom.
  assign psum_shift = (psum >> 4) | (WIDTH'(slice_sum) << (WIDTH - 4));

  assign busy = (state == RUN);

  always_comb begin
    state_nxt = state;
    a_sr_nxt  = a_sr;
    b_sr_nxt  = b_sr;
    psum_nxt  = psum;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    sum_nxt   = sum;
    cout_nxt  = cout;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          a_sr_nxt  = a;
          b_sr_nxt  = b;
          carry_nxt = cin;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // start is deliberately ignored here; in-flight operands live only in the shift registers.
        a_sr_nxt  = a_sr >> 4;
        b_sr_nxt  = b_sr >> 4;
        carry_nxt = slice_cout;
        psum_nxt  = psum_shift;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == LAST) begin
          sum_nxt   = psum_shift;
          cout_nxt  = slice_cout;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      a_sr  <= a_sr_nxt;
      b_sr  <= b_sr_nxt;
      psum  <= psum_nxt;
      carry <= carry_nxt;
      cnt   <= cnt_nxt;
      sum   <= sum_nxt;
      cout  <= cout_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a WIDTH=16 and a WIDTH=4 instance driven by directed vectors.
// Expected results are queued at issue time; monitors pop and compare on every done pulse.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start16, start4;
  logic [15:0] a16, b16, sum16;
  logic [3:0]  a4, b4, sum4;
  logic        cin16, cin4;
  logic        busy16, busy4, done16, done4, cout16, cout4;

  typedef struct {
    logic [15:0] s;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  exp_t m16, m4;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done16: done with nothing outstanding, sum 0x%0h (cycle %0d)", sum16, cyc);
      end else begin
        m16 = q16.pop_front();
        chk("sum16", 32'(sum16), 32'(m16.s));
        chk("cout16", 32'(cout16), 32'(m16.c));
        chk("latency16", 32'(cyc), 32'(m16.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done4: done with nothing outstanding, sum 0x%0h (cycle %0d)", sum4, cyc);
      end else begin
        m4 = q4.pop_front();
        chk("sum4", 32'(sum4), 32'(m4.s));
        chk("cout4", 32'(cout4), 32'(m4.c));
        chk("latency4", 32'(cyc), 32'(m4.cyc));
      end
    end
  end

  // Pulse start for one sampled edge; if acc, the add is expected to complete NIB=4 cycles after E0.
  task automatic issue16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input bit acc, input logic [15:0] es, input logic ec);
    exp_t e;
    @(posedge clk); #1;
    a16 = ta; b16 = tb; cin16 = tc; start16 = 1'b1;
    if (acc) begin
      e.s = es; e.c = ec; e.cyc = cyc + 1 + 4;
      q16.push_back(e);
    end
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                        input logic [3:0] es, input logic ec);
    exp_t e;
    @(posedge clk); #1;
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    e.s = {12'h000, es}; e.c = ec; e.cyc = cyc + 1 + 1;
    q4.push_back(e);
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q16.size() != 0 || q4.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    chk("drain_outstanding", 32'(q16.size() + q4.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start4 = 1'b0;  a4 = '0;  b4 = '0;  cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    chk("rst_sum16", 32'(sum16), 32'd0);
    chk("rst_cout16", 32'(cout16), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_sum4", 32'(sum4), 32'd0);
    reset = 1'b0;

    // 1: basic add with busy window of exactly 4 cycles.
    issue16(16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2233, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_run16", 32'(busy16), 32'd1);
      @(posedge clk); #1;
    end
    chk("busy_end16", 32'(busy16), 32'd0);
    drain();

    // 2: full carry ripple through every nibble.
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1);
    drain();
    issue16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    drain();

    // 3: start while busy is ignored; start in the done cycle is accepted back-to-back.
    issue16(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0);
    issue16(16'h7000, 16'h7000, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    issue16(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1);
    drain();

    // 5: operand inputs wander during RUN without affecting the add.
    issue16(16'h00F0, 16'h0010, 1'b1, 1'b1, 16'h0101, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    end
    drain();

    // 4: reset in the middle of an add aborts it with no done and clears the result.
    issue16(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy16", 32'(busy16), 32'd0);
    chk("abort_done16", 32'(done16), 32'd0);
    chk("abort_sum16", 32'(sum16), 32'd0);
    chk("abort_cout16", 32'(cout16), 32'd0);
    repeat (6) @(posedge clk);
    issue16(16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0);
    drain();

    // 6: WIDTH=4 instance, single RUN cycle, including back-to-back requests.
    issue4(4'd9, 4'd8, 1'b0, 4'd1, 1'b1);
    issue4(4'd7, 4'd8, 1'b1, 4'd0, 1'b1);
    issue4(4'd3, 4'd4, 1'b0, 4'd7, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
